nibble_serial_adder: RTL and testbench

Sequencer that performs a wide (4·NIB-bit) add or subtract by streaming operand nibbles, LSB first, through one external 4-bit carry-select adder slice. Each cycle it drives that slice and captures the slice's sum and carry-out. It sits directly upstream and downstream of the slice. It accepts operands over a valid/ready handshake, runs NIB cycles, and presents the result over a second valid/ready handshake.

---
 rtl/nibble_serial_adder.sv | 135 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: streams a 4*NIB-bit add/subtract through an external
// 4-bit adder slice, one nibble per cycle, LSB first, with valid/ready on
// both the operand side and the result side.
module nibble_serial_adder #(
    parameter int NIB = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4*NIB-1:0] op_a,
    input  logic [4*NIB-1:0] op_b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4*NIB-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_s,
    input  logic             add_cout
);

    localparam int W  = 4 * NIB;
    localparam int IW = $clog2(NIB);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [W-1:0]  sum_r;
    logic          carry_r;
    logic          cout_r;
    logic          ovf_r;
    logic [IW-1:0] idx;

    logic [IW+1:0] base;
    logic          last_nib;
    logic          accept;
    logic          ovf_nxt;

    // Bit offset of the current nibble, and the "final nibble" marker.
    assign base     = {idx, 2'b00};
    assign last_nib = (idx == IW'(NIB - 1));
    assign accept   = (state == IDLE) && in_valid;

    // Signed overflow: both operand signs agree (b_r already inverted for
    // subtract) but the MSB nibble's sum bit disagrees with them.
    assign ovf_nxt  = (a_r[W-1] == b_r[W-1]) && (add_s[3] != a_r[W-1]);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and slice drive; the slice sees zeros outside RUN.
    always_comb begin
        state_nxt = state;
        add_a     = 4'd0;
        add_b     = 4'd0;
        add_cin   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                add_a   = a_r[base +: 4];
                add_b   = b_r[base +: 4];
                add_cin = carry_r;
                if (last_nib) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture on accept, then per-nibble result/carry capture in RUN;
    // results stay held through DONE and the following IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            idx     <= '0;
        end else if (accept) begin
            a_r     <= op_a;
            b_r     <= sub ? ~op_b : op_b;
            carry_r <= sub ? 1'b1 : cin;
            idx     <= '0;
            sum_r   <= '0;
        end else if (state == RUN) begin
            sum_r[base +: 4] <= add_s;
            carry_r          <= add_cout;
            idx              <= idx + IW'(1);
            if (last_nib) begin
                cout_r <= add_cout;
                ovf_r  <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder: models the external 4-bit slice,
// runs a directed vector table, multi-cycle corner sequences, and random
// operations against an arithmetic reference model.
module tb_nibble_serial_adder;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_s;
    logic         add_cout;
    logic [4:0]   slice_res;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs [8];

    nibble_serial_adder #(.NIB(NIB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // External combinational 4-bit adder slice.
    assign slice_res = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
    assign add_s     = slice_res[3:0];
    assign add_cout  = slice_res[4];

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic; overflow is a true signed range check.
    function automatic logic [W+1:0] refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic c, input logic s);
        logic [31:0]  ua;
        logic [31:0]  ub;
        logic [31:0]  res;
        int           sa;
        int           sb;
        int           full_s;
        logic         co;
        logic         ov;
        ua = {16'd0, a};
        ub = {16'd0, b};
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            res    = ua - ub;
            co     = (ua >= ub);
            full_s = sa - sb;
        end else begin
            res    = ua + ub + {31'd0, c};
            co     = res[W];
            full_s = sa + sb + (c ? 1 : 0);
        end
        ov = (full_s > 32767) || (full_s < -32768);
        return {co, ov, res[W-1:0]};
    endfunction

    // Drive one request, check the first slice nibble, wait for the result.
    task automatic applyStimulus(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic s);
        int n;
        logic [3:0] exp_b0;
        @(negedge clk);
        checkOutput({name, " in_ready idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        cin      = c;
        sub      = s;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        exp_b0   = s ? ~b[3:0] : b[3:0];
        checkOutput({name, " in_ready busy"}, 32'(in_ready), 32'd0);
        checkOutput({name, " add_a nib0"}, 32'(add_a), 32'(a[3:0]));
        checkOutput({name, " add_b nib0"}, 32'(add_b), 32'(exp_b0));
        checkOutput({name, " add_cin nib0"}, 32'(add_cin), s ? 32'd1 : 32'(c));
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " latency"}, 32'(n), 32'(NIB));
    endtask

    // Complete the result handshake and check the block returns to idle.
    task automatic releaseResult(input string name, input logic [W-1:0] exp_sum);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({name, " out_valid after hs"}, 32'(out_valid), 32'd0);
        checkOutput({name, " in_ready after hs"}, 32'(in_ready), 32'd1);
        checkOutput({name, " sum held idle"}, 32'(sum), 32'(exp_sum));
        checkOutput({name, " add_a idle"}, 32'(add_a), 32'd0);
    endtask

    initial begin
        logic [W+1:0] r;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rs;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[6] = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        // Reset state
        #2;
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset sum", 32'(sum), 32'd0);
        checkOutput("reset cout", 32'(cout), 32'd0);
        checkOutput("reset ovf", 32'(ovf), 32'd0);
        checkOutput("reset add_a", 32'(add_a), 32'd0);
        checkOutput("reset add_b", 32'(add_b), 32'd0);
        checkOutput("reset add_cin", 32'(add_cin), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            checkOutput($sformatf("vec%0d sum", i), 32'(sum), 32'(vecs[i].exp_sum));
            checkOutput($sformatf("vec%0d cout", i), 32'(cout), 32'(vecs[i].exp_cout));
            checkOutput($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
            releaseResult($sformatf("vec%0d", i), vecs[i].exp_sum);
        end

        // Backpressure: hold out_ready low, a second request must wait
        applyStimulus("bp1", 16'h1234, 16'h1111, 1'b0, 1'b0);
        in_valid = 1'b1;
        op_a     = 16'h0F0F;
        op_b     = 16'h0101;
        cin      = 1'b0;
        sub      = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("bp hold%0d out_valid", k), 32'(out_valid), 32'd1);
            checkOutput($sformatf("bp hold%0d sum", k), 32'(sum), 32'h2345);
            checkOutput($sformatf("bp hold%0d in_ready", k), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bp in_ready after hs", 32'(in_ready), 32'd1);
        checkOutput("bp out_valid after hs", 32'(out_valid), 32'd0);
        checkOutput("bp sum held idle", 32'(sum), 32'h2345);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bp second accepted", 32'(in_ready), 32'd0);
        begin
            int n;
            n = 0;
            while (out_valid !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            checkOutput("bp2 latency", 32'(n), 32'(NIB));
        end
        checkOutput("bp2 sum", 32'(sum), 32'h0E0E);
        checkOutput("bp2 cout", 32'(cout), 32'd1);
        checkOutput("bp2 ovf", 32'(ovf), 32'd0);
        releaseResult("bp2", 16'h0E0E);

        // Reset asserted mid-RUN at idx 2
        @(negedge clk);
        in_valid = 1'b1;
        op_a     = 16'h1111;
        op_b     = 16'h2222;
        cin      = 1'b0;
        sub      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst midrun add_a nib2", 32'(add_a), 32'h1);
        checkOutput("rst midrun partial sum", 32'(sum), 32'h0033);
        rst_n = 1'b0;
        #1;
        checkOutput("rst midrun in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst midrun out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst midrun sum", 32'(sum), 32'd0);
        checkOutput("rst midrun cout", 32'(cout), 32'd0);
        checkOutput("rst midrun ovf", 32'(ovf), 32'd0);
        checkOutput("rst midrun add_a", 32'(add_a), 32'd0);
        checkOutput("rst midrun add_cin", 32'(add_cin), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput($sformatf("rst no out_valid%0d", k), 32'(out_valid), 32'd0);
        end
        applyStimulus("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0);
        checkOutput("post_rst sum", 32'(sum), 32'h0100);
        checkOutput("post_rst cout", 32'(cout), 32'd0);
        checkOutput("post_rst ovf", 32'(ovf), 32'd0);
        releaseResult("post_rst", 16'h0100);

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            r  = refModel(ra, rb, rc, rs);
            applyStimulus($sformatf("rnd%0d", i), ra, rb, rc, rs);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checkOutput($sformatf("rnd%0d sum", i), 32'(sum), 32'(r[W-1:0]));
            checkOutput($sformatf("rnd%0d cout", i), 32'(cout), 32'(r[W+1]));
            checkOutput($sformatf("rnd%0d ovf", i), 32'(ovf), 32'(r[W]));
            releaseResult($sformatf("rnd%0d", i), r[W-1:0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
